// File: rtl/store_mem_unit_pkg.sv
// Shared types for the store functional unit: FSM states, store funct3 codes and the RS entry.
package rv32i_types;

    localparam int ROB_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_DONE = 2'd2
    } store_fsm_t;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic [31:0]          rs1_data;
        logic [31:0]          rs2_data;
        logic [31:0]          imm_value;
        logic [2:0]           funct3;
        logic [ROB_WIDTH-1:0] rob_idx;
    } ResEntrySt_reg_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/store_mem_unit_align.sv
// Combinational store formatting: word address, byte mask and lane-shifted data.
// STORE_MISALIGN_CHK_EN enables suppression and flagging of misaligned sh/sw.
module store_align
    import rv32i_types::*;
(
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_imm,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_addr,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic        o_misalign
);

    logic [31:0] w_addr;
    logic [1:0]  w_s;

    always_comb begin
        w_addr     = i_rs1 + i_imm;
        w_s        = w_addr[1:0];
        o_addr     = word_align(w_addr);
        o_wmask    = 4'b0000;
        o_wdata    = 32'h0;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_SB: begin
                o_wmask = 4'b0001 << w_s;
                o_wdata = {24'h0, i_rs2[7:0]} << {w_s, 3'b000};
            end
            F3_SH: begin
                o_wmask = 4'b0011 << w_s;
                o_wdata = w_s[1] ? {i_rs2[15:0], 16'h0} : {16'h0, i_rs2[15:0]};
`ifdef STORE_MISALIGN_CHK_EN
                o_misalign = w_s[0];
`endif
            end
            F3_SW: begin
                o_wmask = 4'b1111;
                o_wdata = i_rs2;
`ifdef STORE_MISALIGN_CHK_EN
                o_misalign = (w_s != 2'b00);
`endif
            end
            default: ;
        endcase
        // A flagged store never reaches memory
        if (o_misalign)
            o_wmask = 4'b0000;
    end

endmodule

// File: rtl/store_mem_unit.sv
// Store functional unit: accepts one committed store, holds a dmem write until dmem_resp,
// then pulses st_done. STORE_MISALIGN_CHK_EN enables misaligned-store reporting.
module store_mem_unit
    import rv32i_types::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue,
    input  ResEntrySt_reg_t      entry_in,
    output logic                 fu_running,
    output logic [31:0]          dmem_addr,
    output logic [3:0]           dmem_wmask,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_resp,
    output logic                 st_done,
    output logic [ROB_WIDTH-1:0] st_rob_idx,
    output logic                 st_misalign
);

    store_fsm_t           r_state;
    store_fsm_t           w_state_next;
    logic [31:0]          r_addr;
    logic [3:0]           r_wmask;
    logic [31:0]          r_wdata;
    logic [ROB_WIDTH-1:0] r_rob_idx;
    logic                 r_misalign;

    logic [31:0]          w_addr;
    logic [3:0]           w_wmask;
    logic [31:0]          w_wdata;
    logic                 w_misalign;
    logic                 w_accept;

    store_align u_align (
        .i_rs1      (entry_in.rs1_data),
        .i_rs2      (entry_in.rs2_data),
        .i_imm      (entry_in.imm_value),
        .i_funct3   (entry_in.funct3),
        .o_addr     (w_addr),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign)
    );

    assign w_accept = issue && (r_state != ST_MEM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (issue)
                    w_state_next = (w_wmask != 4'b0000) ? ST_MEM : ST_DONE;
                else
                    w_state_next = ST_IDLE;
            end
            ST_MEM: begin
                if (dmem_resp)
                    w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= 32'h0;
            r_wmask    <= 4'b0000;
            r_wdata    <= 32'h0;
            r_rob_idx  <= '0;
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= w_addr;
            r_wmask    <= w_wmask;
            r_wdata    <= w_wdata;
            r_rob_idx  <= entry_in.rob_idx;
            r_misalign <= w_misalign;
        end
    end

    // Request is visible only in MEM, so reset drops it in the same cycle
    always_comb begin
        fu_running  = (r_state == ST_MEM);
        dmem_addr   = r_addr;
        dmem_wdata  = r_wdata;
        dmem_wmask  = (r_state == ST_MEM) ? r_wmask : 4'b0000;
        st_done     = (r_state == ST_DONE);
        st_rob_idx  = r_rob_idx;
        st_misalign = (r_state == ST_DONE) && r_misalign;
    end

    a_no_issue_in_mem: assert property (@(posedge clk) disable iff (rst)
        !(issue && r_state == ST_MEM));

endmodule

// File: tb/tb_store_mem_unit.sv
// Scoreboard bench for store_mem_unit: directed cases then randomized stores against a byte-lane model.
module tb_store_mem_unit;
    import rv32i_types::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 issue;
    ResEntrySt_reg_t      entry_in;
    logic                 fu_running;
    logic [31:0]          dmem_addr;
    logic [3:0]           dmem_wmask;
    logic [31:0]          dmem_wdata;
    logic                 dmem_resp;
    logic                 st_done;
    logic [ROB_WIDTH-1:0] st_rob_idx;
    logic                 st_misalign;

    store_mem_unit dut (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .entry_in    (entry_in),
        .fu_running  (fu_running),
        .dmem_addr   (dmem_addr),
        .dmem_wmask  (dmem_wmask),
        .dmem_wdata  (dmem_wdata),
        .dmem_resp   (dmem_resp),
        .st_done     (st_done),
        .st_rob_idx  (st_rob_idx),
        .st_misalign (st_misalign)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        int          start;
    } req_t;

    typedef struct {
        logic [ROB_WIDTH-1:0] rob;
        logic                 mis;
        int                   at;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: place store bytes into memory lanes from the effective byte address
    function automatic void model(input ResEntrySt_reg_t e, output req_t r,
                                  output bit has_req, output bit mis);
        logic [31:0] a;
        logic [7:0]  lane [4];
        bit          en [4];
        int          s;
        a   = e.rs1_data + e.imm_value;
        s   = int'(a % 4);
        mis = 1'b0;
        for (int b = 0; b < 4; b++) begin
            lane[b] = 8'h00;
            en[b]   = 1'b0;
        end
        case (e.funct3)
            3'd0: begin
                en[s]   = 1'b1;
                lane[s] = e.rs2_data[7:0];
            end
            3'd1: begin
                for (int b = 0; b < 2; b++)
                    lane[(s >= 2 ? 2 : 0) + b] = e.rs2_data[8*b +: 8];
                en[s] = 1'b1;
                if (s + 1 < 4) en[s+1] = 1'b1;
`ifdef STORE_MISALIGN_CHK_EN
                if (s % 2 != 0) mis = 1'b1;
`endif
            end
            3'd2: begin
                for (int b = 0; b < 4; b++) begin
                    lane[b] = e.rs2_data[8*b +: 8];
                    en[b]   = 1'b1;
                end
`ifdef STORE_MISALIGN_CHK_EN
                if (s != 0) mis = 1'b1;
`endif
            end
            default: ;
        endcase
        r.addr  = a - 32'(s);
        r.wmask = 4'b0000;
        r.wdata = 32'h0;
        r.start = 0;
        for (int b = 0; b < 4; b++) begin
            r.wmask[b]       = en[b] && !mis;
            r.wdata[8*b +: 8] = lane[b];
        end
        has_req = (r.wmask != 4'b0000);
    endfunction

    function automatic ResEntrySt_reg_t mk(input logic [31:0] rs1, input logic [31:0] imm,
                                           input logic [31:0] rs2, input logic [2:0] f3,
                                           input logic [ROB_WIDTH-1:0] rob);
        ResEntrySt_reg_t e;
        e.rs1_data  = rs1;
        e.rs2_data  = rs2;
        e.imm_value = imm;
        e.funct3    = f3;
        e.rob_idx   = rob;
        return e;
    endfunction

    // Called at a negedge with the unit free; returns at the negedge where the store is in DONE
    task automatic run_store(input ResEntrySt_reg_t e, input int delay);
        req_t r;
        bit   has_req;
        bit   mis;
        check("free_at_issue", fu_running, 1'b0);
        model(e, r, has_req, mis);
        r.start = cyc + 1;
        if (has_req) req_q.push_back(r);
        done_q.push_back('{rob: e.rob_idx, mis: mis, at: cyc + (has_req ? 2 + delay : 1)});
        $display("store f3=%0d addr=0x%08h rs2=0x%08h rob=%0d delay=%0d -> wmask=%b wdata=0x%08h mis=%0b",
                 e.funct3, e.rs1_data + e.imm_value, e.rs2_data, e.rob_idx, delay, r.wmask, r.wdata, mis);
        issue    = 1'b1;
        entry_in = e;
        @(negedge clk);
        issue    = 1'b0;
        entry_in = '0;
        if (has_req) begin
            for (int k = 0; k <= delay; k++) begin
                dmem_resp = (k == delay);
                @(negedge clk);
            end
            dmem_resp = 1'b0;
        end
    endtask

    // Idle cycles with stray responses that the unit must ignore
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            dmem_resp = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        dmem_resp = 1'b0;
    endtask

    // Monitor: compares every DUT-visible output against the scoreboard queues
    initial begin
        forever begin
            bit exp_busy;
            bit exp_done;
            @(negedge clk);
            #1;
            if (!rst) begin
                exp_busy = 1'b0;
                if (req_q.size() > 0)
                    exp_busy = (req_q[0].start <= cyc);
                check("fu_running", fu_running, exp_busy);
                if (exp_busy) begin
                    check("req_addr", dmem_addr, req_q[0].addr);
                    check("req_wmask", dmem_wmask, req_q[0].wmask);
                    check("req_wdata", dmem_wdata, req_q[0].wdata);
                    if (dmem_resp) void'(req_q.pop_front());
                end else begin
                    check("idle_wmask", dmem_wmask, 4'b0000);
                end
                exp_done = 1'b0;
                if (done_q.size() > 0)
                    exp_done = (done_q[0].at == cyc);
                check("st_done", st_done, exp_done);
                if (exp_done) begin
                    check("st_rob_idx", st_rob_idx, done_q[0].rob);
                    check("st_misalign", st_misalign, done_q[0].mis);
                    void'(done_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        issue     = 1'b0;
        dmem_resp = 1'b0;
        entry_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_fu_running", fu_running, 1'b0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        check("rst_dmem_wmask", dmem_wmask, 4'b0000);
        check("rst_dmem_wdata", dmem_wdata, 32'h0);
        check("rst_st_done", st_done, 1'b0);
        check("rst_st_rob_idx", st_rob_idx, 32'h0);
        check("rst_st_misalign", st_misalign, 1'b0);
        rst = 1'b0;
        idle(2);

        run_store(mk(32'h1000, 32'h4, 32'hDEADBEEF, F3_SW, 3'd1), 0);
        idle(1);
        run_store(mk(32'h1000, 32'h3, 32'h000000AB, F3_SB, 3'd2), 1);
        idle(1);
        run_store(mk(32'h2000, 32'h2, 32'h00001234, F3_SH, 3'd3), 4);
        run_store(mk(32'h3000, 32'h8, 32'h11223344, F3_SW, 3'd4), 0);
        run_store(mk(32'h3001, 32'h0, 32'h55667788, F3_SB, 3'd5), 2);
        run_store(mk(32'h1000, 32'h1, 32'hCAFEF00D, F3_SW, 3'd6), 0);
        run_store(mk(32'h2000, 32'h3, 32'h0000BEEF, F3_SH, 3'd7), 0);
        run_store(mk(32'hFFFFFFFF, 32'h2, 32'h000000C3, F3_SB, 3'd0), 0);
        run_store(mk(32'h4000, 32'h0, 32'h12345678, 3'b111, 3'd1), 0);
        idle(2);

        // Reset while a request is held: dropped at once, no completion
        begin
            ResEntrySt_reg_t e;
            req_t r;
            bit has_req;
            bit mis;
            e = mk(32'h5000, 32'h0, 32'hA5A5A5A5, F3_SW, 3'd2);
            model(e, r, has_req, mis);
            r.start = cyc + 1;
            req_q.push_back(r);
            done_q.push_back('{rob: e.rob_idx, mis: mis, at: cyc + 1000});
            $display("store f3=2 addr=0x00005000 rob=2 interrupted by reset");
            issue    = 1'b1;
            entry_in = e;
            @(negedge clk);
            issue    = 1'b0;
            entry_in = '0;
            @(negedge clk);
            #3 rst = 1'b1;
            #1;
            check("rst_mid_wmask", dmem_wmask, 4'b0000);
            check("rst_mid_fu_running", fu_running, 1'b0);
            check("rst_mid_st_done", st_done, 1'b0);
            req_q.delete();
            done_q.delete();
            @(negedge clk);
            rst = 1'b0;
            idle(1);
            run_store(mk(32'h5000, 32'h4, 32'h0BADCAFE, F3_SW, 3'd3), 1);
            idle(1);
        end

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f3;
            logic [31:0] imm;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel < 3)      f3 = F3_SB;
            else if (sel < 6) f3 = F3_SH;
            else if (sel < 9) f3 = F3_SW;
            else              f3 = 3'($urandom_range(3, 7));
            imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
            run_store(mk($urandom, imm, $urandom, f3, 3'($urandom_range(0, 7))),
                      $urandom_range(0, 4));
            idle($urandom_range(0, 2));
        end

        idle(4);
        check("req_queue_drained", req_q.size(), 32'd0);
        check("done_queue_drained", done_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
